stack_arbiter: RTL
==================

// Module: stack_arbiter
// PURPOSE
//   Shares one 4-bit LIFO stack between two requesters (port 0, port 1).
//   Accepts push/pop requests, arbitrates round-robin, and drives the stack's
//   push/pop/data_In controls as one-cycle pulses. Returns popped data.
//   Rejects push-when-full and pop-when-empty without touching the stack.
//   Sits between client logic and the stack instance; the sole driver of its controls.
// PARAMETERS
//   DATA_W     4   data width; must match the stack's data_In/data_Out
//   FIRST_PRIO 0   port that wins the first contended arbitration after reset
// PORTS
//   clk           in   1       rising-edge clock
//   rstN          in   1       asynchronous, active-low reset
//   req0/req1     in   1       request; held high until matching done
//   op0/op1       in   1       0 = push, 1 = pop; stable while req high
//   wdata0/wdata1 in   DATA_W  push data; stable while req high
//   gnt0/gnt1     out  1       1-cycle pulse: request accepted
//   done0/done1   out  1       1-cycle pulse: transaction complete
//   err0/err1     out  1       valid with done: request rejected (full/empty)
//   rdata         out  DATA_W  popped value; valid with done of a good pop
//   busy          out  1       high in every state except IDLE
//   stk_push      out  1       to stack push
//   stk_pop       out  1       to stack pop
//   stk_data_In   out  DATA_W  to stack data_In
//   stk_data_Out  in   DATA_W  from stack data_Out; valid the cycle after stk_pop
//   stk_full      in   1       from stack full
//   stk_empty     in   1       from stack empty
// BEHAVIOUR
//   Reset (rstN=0, async): state=IDLE; all outputs 0; rdata=0; rr pointer=FIRST_PRIO.
//   FSM: IDLE -> ISSUE -> [CAPT] -> RESP -> IDLE;  IDLE -> REJ -> IDLE.
//   IDLE: sample req0/req1. One high -> pick it; both -> pick rr pointer port.
//     Latch id/op/wdata; pulse gnt<id>. If (push & stk_full) | (pop & stk_empty)
//     -> REJ, else -> ISSUE. No req -> stay.
//   ISSUE: exactly one cycle of stk_push (stk_data_In=latched wdata) or stk_pop.
//     push -> RESP; pop -> CAPT.
//   CAPT: register stk_data_Out into rdata -> RESP.
//   RESP: done<id>=1, err<id>=0 for one cycle; toggle rr pointer to other port -> IDLE.
//   REJ: done<id>=1, err<id>=1 for one cycle; no stack strobe; rdata unchanged;
//     toggle rr pointer -> IDLE.
//   Latency from accept edge (gnt cycle): push done +2 cycles, pop +3, reject +1.
//   stk_push/stk_pop never high together; never high outside ISSUE.
//   stk_data_In = 0 except in ISSUE of a push.
//   rdata holds last good popped value until the next good pop.
//   Full/empty checked only in IDLE, at accept; single owner, so no change before ISSUE.
//   req still high in the IDLE after done = a new request (back-to-back legal).
//   Uncontended request: rr pointer still toggles after completion.
//   rstN low mid-transaction: abort at once, return to IDLE, no done pulse;
//     any stk_ strobe drops immediately.
// TESTING
//   1 Reset, req0 push 2,1,2,7,6,9,3,4 serially -> 8 done0, err0=0, 8 stk_push pulses,
//     stk_data_In matches; stk_full=1 at end.
//   2 Full, req1 push 5 -> gnt1, done1+err1 one cycle later; no stk_push.
//   3 Full, req0 pop x3 -> rdata 4,3,9 on each done0, 3 cycles after its gnt0.
//   4 After reset (empty), req1 pop -> err1=1; rdata stays 0.
//   5 req0 push 1 and req1 push 5 held together -> grants alternate 0,1,0,1.
//     FIRST_PRIO=0 gives port 0 first; pops return in LIFO order of completed pushes.
//   6 Drop rstN in ISSUE of a pop -> outputs 0 at once, busy=0;
//     next request completes normally.

Source files
------------

// File: rtl/stack_arbiter.sv
// Round-robin arbiter that lets two requesters share one LIFO stack.
// It drives the stack's push/pop strobes as single-cycle pulses and returns popped data.
module stack_arbiter #(
  parameter int DATA_W     = 4,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_data_In,
  input  logic [DATA_W-1:0] stk_data_Out,
  input  logic              stk_full,
  input  logic              stk_empty,
  output logic [2:0]        state_dbg
);

  // Handshake: a client holds req/op/wdata stable until its done pulse. gnt
  // marks the IDLE cycle in which the request is taken, done ends it, and err
  // qualifies done. A req still high in the following IDLE is a new request.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] RESP  = 3'd3;
  localparam logic [2:0] REJ   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              id_q, id_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick;
  logic              reject;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    rr_d        = rr_q;
    rdata_d     = rdata_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_In = '0;
    pick        = (req0 && req1) ? rr_q : req1;
    reject      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          id_d    = pick;
          op_d    = pick ? op1 : op0;
          wdata_d = pick ? wdata1 : wdata0;
          // gnt is combinational, so gate it with reset to keep outputs quiet.
          gnt0    = rstN && !pick;
          gnt1    = rstN && pick;
          reject  = op_d ? stk_empty : stk_full;
          state_d = reject ? REJ : ISSUE;
        end
      end
      ISSUE: begin
        if (op_q) begin
          stk_pop = 1'b1;
          state_d = CAPT;
        end else begin
          stk_push    = 1'b1;
          stk_data_In = wdata_q;
          state_d     = RESP;
        end
      end
      CAPT: begin
        rdata_d = stk_data_Out;
        state_d = RESP;
      end
      RESP: begin
        done0   = !id_q;
        done1   = id_q;
        rr_d    = !rr_q;
        state_d = IDLE;
      end
      REJ: begin
        done0   = !id_q;
        done1   = id_q;
        err0    = !id_q;
        err1    = id_q;
        rr_d    = !rr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      wdata_q <= '0;
      rr_q    <= FIRST_PRIO;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rr_q    <= rr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
